mac_dot_ctrl: RTL and testbench
===============================

// Module: mac_dot_ctrl
// PURPOSE
//  Sequencer for one 8x8->20-bit MAC unit (registered multiply, then registered accumulate, sclr clears both).
//  Computes dot products of two vectors held in sync-read operand RAMs and returns one result per start/done transaction.
//  Clears the MAC, issues RAM reads, and zero-gates the MAC operands on idle cycles.
//  Waits for the 2-stage MAC pipeline to drain, then captures the sum.
// PARAMETERS
//  ADDR_W  8   operand RAM address width; addresses wrap mod 2^ADDR_W
//  LEN_W   8   vector length width; length range 0..2^LEN_W-1
//  ACC_W   20  MAC accumulator width; must match the MAC output
// PORTS
//  clk        in   1       clock
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       request; sampled only in IDLE
//  vec_len    in   LEN_W   number of element pairs L; latched on start
//  base_a     in   ADDR_W  vector A base address; latched on start
//  base_b     in   ADDR_W  vector B base address; latched on start
//  rd_en      out  1       RAM read strobe; data is returned one cycle later
//  a_addr     out  ADDR_W  RAM A address
//  b_addr     out  ADDR_W  RAM B address
//  mem_a      in   8       RAM A read data
//  mem_b      in   8       RAM B read data
//  mac_a      out  8       MAC i_a: mem_a when the read is valid, else 0
//  mac_b      out  8       MAC i_b: mem_b when the read is valid, else 0
//  mac_sclr   out  1       MAC synchronous clear
//  mac_o      in   ACC_W   MAC accumulator output
//  busy       out  1       high in every state except IDLE
//  done       out  1       one-cycle pulse; result is valid in the same cycle
//  result     out  ACC_W   captured dot product; held until the next capture
//  ovf        out  1       wrap flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0, including result and ovf; idx=0; vld_d=0.
//   The MAC shares rst_n, so reset mid-operation aborts cleanly and no done pulse is issued.
//  FSM: IDLE -> CLEAR -> ISSUE -> DRAIN -> DONE -> IDLE.
//  IDLE:  start=1 latches vec_len/base_a/base_b and moves to CLEAR. start is ignored in every other state.
//  CLEAR: one cycle, mac_sclr=1.
//   If L==0: next state is DONE, result<=0.
//   Else: next state is ISSUE, idx=0.
//  ISSUE: L cycles with rd_en=1, a_addr=base_a+idx, b_addr=base_b+idx; idx increments each cycle.
//   Leaves after the cycle in which idx==L-1.
//  vld_d: rd_en delayed one cycle.
//   mac_a = vld_d ? mem_a : 0; mac_b = vld_d ? mem_b : 0 (combinational gating).
//   Zero products therefore enter the accumulator on all non-data cycles.
//  DRAIN: exactly 3 cycles (last data cycle, mul stage, psum stage).
//   At the end of the 3rd cycle, result<=mac_o.
//  DONE: done=1 for one cycle, then IDLE. A start in DONE is ignored.
//  Latency: start sampled in cycle 0, then CLEAR in cycle 1, ISSUE in cycles 2..L+1, done in cycle L+5.
//   For L=0, done is in cycle 2.
//  Arithmetic: the sum wraps mod 2^ACC_W (MAC behaviour). The controller never saturates.
//  Back-to-back: the earliest new start is the cycle after DONE, i.e. one IDLE cycle between transactions.
// CONFIGURATION
//  MAC_OVF_EN defined:
//   - ovf is cleared in CLEAR.
//   - ovf is set (sticky) on any cycle in ISSUE/DRAIN where mac_o < mac_o of the previous cycle.
//   - A single product is below 2^ACC_W, so every wrap is detected.
//   - ovf is valid alongside done and held until the next CLEAR.
//  MAC_OVF_EN undefined: ovf tied 0; no compare logic or previous-value register.
// TESTING
//  1) A=[1,2,3,4], B=[5,6,7,8], bases 0, L=4, start cycle 0 -> rd_en cycles 2..5; done cycle 9; result=70.
//  2) L=0 -> mac_sclr cycle 1; done cycle 2; result=0; rd_en never asserted.
//  3) L=17, all elements 255 -> result=56849 (1105425 mod 2^20); ovf=1 with MAC_OVF_EN, 0 without.
//     L=16, all 255 -> 1040400, ovf=0.
//  4) base_a=0xFE, base_b=0x10, L=4 -> a_addr FE,FF,00,01; b_addr 10..13.
//  5) start pulsed in ISSUE and in DONE -> ignored; exactly one done; result is unchanged by the extra pulses.
//  6) rst_n low mid-ISSUE -> busy=0, done=0, result=0 immediately.
//     Next run of test 1 -> result=70.

Source files
------------

// File: rtl/mac_dot_ctrl_if.sv
// Request, RAM and MAC connections of the dot-product sequencer.
// master = requester/RAM/MAC side, slave = mac_dot_ctrl.
interface mac_dot_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 20
);
  logic              start;
  logic [LEN_W-1:0]  vec_len;
  logic [ADDR_W-1:0] base_a;
  logic [ADDR_W-1:0] base_b;
  logic              rd_en;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [7:0]        mem_a;
  logic [7:0]        mem_b;
  logic [7:0]        mac_a;
  logic [7:0]        mac_b;
  logic              mac_sclr;
  logic [ACC_W-1:0]  mac_o;
  logic              busy;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic              ovf;

  modport master (
    output start, vec_len, base_a, base_b, mem_a, mem_b, mac_o,
    input  rd_en, a_addr, b_addr, mac_a, mac_b, mac_sclr, busy, done, result, ovf
  );

  modport slave (
    input  start, vec_len, base_a, base_b, mem_a, mem_b, mac_o,
    output rd_en, a_addr, b_addr, mac_a, mac_b, mac_sclr, busy, done, result, ovf
  );
endinterface

// File: rtl/mac_dot_ctrl.sv
// Dot-product sequencer for one 2-stage 8x8 MAC fed from two sync-read operand RAMs.
// Optional MAC_OVF_EN: sticky accumulator-wrap flag on ovf (tied 0 when undefined).
//
// state   | meaning
// S_IDLE  | waiting for start; latches length and base addresses
// S_CLEAR | one cycle of mac_sclr
// S_ISSUE | L cycles of RAM reads
// S_DRAIN | 3 cycles for last data + MAC pipeline; captures mac_o at the end
// S_DONE  | one-cycle done pulse
module mac_dot_ctrl #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8,
  parameter int ACC_W  = 20
) (
  input logic           clk,
  input logic           rst_n,
  mac_dot_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [ADDR_W-1:0] b_addr_q;
  logic [1:0]        drain_q;
  logic              rd_en_q;
  logic              vld_q;
  logic              sclr_q;
  logic              busy_q;
  logic              done_q;
  logic [ACC_W-1:0]  result_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      a_addr_q <= '0;
      b_addr_q <= '0;
      drain_q  <= '0;
      rd_en_q  <= 1'b0;
      vld_q    <= 1'b0;
      sclr_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      vld_q <= rd_en_q;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            len_q    <= bus.vec_len;
            a_addr_q <= bus.base_a;
            b_addr_q <= bus.base_b;
            sclr_q   <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          sclr_q <= 1'b0;
          idx_q  <= '0;
          if (len_q == '0) begin
            result_q <= '0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            rd_en_q <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (idx_q == len_q - LEN_W'(1)) begin
            rd_en_q <= 1'b0;
            drain_q <= 2'd2;
            state_q <= S_DRAIN;
          end else begin
            idx_q    <= idx_q + LEN_W'(1);
            a_addr_q <= a_addr_q + ADDR_W'(1);
            b_addr_q <= b_addr_q + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // drain_q is a down-counter; terminal count marks the cycle the final sum is visible
          if (drain_q == 2'd0) begin
            result_q <= bus.mac_o;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end else begin
            drain_q <= drain_q - 2'd1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en    = rd_en_q;
  assign bus.a_addr   = a_addr_q;
  assign bus.b_addr   = b_addr_q;
  assign bus.mac_a    = vld_q ? bus.mem_a : 8'd0;
  assign bus.mac_b    = vld_q ? bus.mem_b : 8'd0;
  assign bus.mac_sclr = sclr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

`ifdef MAC_OVF_EN
  logic [ACC_W-1:0] prev_q;
  logic             ovf_q;

  // The reference is forced to 0 in CLEAR so the stale pre-clear sum is never compared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      prev_q <= (state_q == S_CLEAR) ? '0 : bus.mac_o;
      if (state_q == S_CLEAR)
        ovf_q <= 1'b0;
      else if ((state_q == S_ISSUE || state_q == S_DRAIN) && (bus.mac_o < prev_q))
        ovf_q <= 1'b1;
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Randomized scoreboard bench for mac_dot_ctrl with behavioural RAM and MAC models.
module tb_mac_dot_ctrl;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 8;
  localparam int ACC_W  = 20;
`ifdef MAC_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  typedef struct {
    int res;
    bit ovf;
    int cyc;
  } exp_t;

  typedef struct {
    int a;
    int b;
  } addr_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_err;
  int   n_chk;
  int   last_res;

  exp_t  exp_q[$];
  addr_t addr_q[$];
  int    sclr_q[$];

  logic [7:0]       ram_a [256];
  logic [7:0]       ram_b [256];
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;

  mac_dot_ctrl_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) bus ();

  mac_dot_ctrl #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .ACC_W(ACC_W)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sync-read RAMs and 2-stage MAC around the controller
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_a <= '0;
      bus.mem_b <= '0;
      prod      <= '0;
      acc       <= '0;
    end else begin
      if (bus.rd_en) begin
        bus.mem_a <= ram_a[bus.a_addr];
        bus.mem_b <= ram_b[bus.b_addr];
      end
      if (bus.mac_sclr) begin
        prod <= '0;
        acc  <= '0;
      end else begin
        prod <= 16'(bus.mac_a) * 16'(bus.mac_b);
        acc  <= acc + ACC_W'(prod);
      end
    end
  end
  assign bus.mac_o = acc;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT shows reads, clears or done
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en) begin
        if (addr_q.size() == 0) chk("unexpected_rd_en", 1, 0);
        else begin
          addr_t e;
          e = addr_q.pop_front();
          chk("a_addr", int'(bus.a_addr), e.a);
          chk("b_addr", int'(bus.b_addr), e.b);
        end
      end
      if (bus.mac_sclr) begin
        if (sclr_q.size() == 0) chk("unexpected_sclr", 1, 0);
        else chk("sclr_cycle", cyc, sclr_q.pop_front());
      end
      if (bus.done) begin
        if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result", int'(bus.result), e.res);
          chk("ovf", int'(bus.ovf), int'(e.ovf));
          chk("done_cycle", cyc, e.cyc);
          last_res = e.res;
        end
      end else if (!bus.busy) begin
        chk("result_held", int'(bus.result), last_res);
      end
    end
  end

  function automatic int ref_sum(input int len, input int ba, input int bb);
    int s = 0;
    for (int i = 0; i < len; i++)
      s += int'(ram_a[8'(ba + i)]) * int'(ram_b[8'(bb + i)]);
    return s;
  endfunction

  // Issues one transaction at the current negedge; returns on the first idle negedge.
  task automatic run(input int len, input int ba, input int bb, input bit extra,
                     input int abort_k, input bit use_c, input int c_res, input bit c_ovf);
    exp_t e;
    int   s;
    int   k;
    s = ref_sum(len, ba, bb);
    e.res = use_c ? c_res : (s % (1 << ACC_W));
    e.ovf = use_c ? c_ovf : (OVF_ON && (s >= (1 << ACC_W)));
    e.cyc = cyc + ((len == 0) ? 2 : len + 5);
    exp_q.push_back(e);
    sclr_q.push_back(cyc + 1);
    for (int i = 0; i < len; i++) begin
      addr_t a;
      a.a = (ba + i) % 256;
      a.b = (bb + i) % 256;
      addr_q.push_back(a);
    end
    bus.vec_len = LEN_W'(len);
    bus.base_a  = ADDR_W'(ba);
    bus.base_b  = ADDR_W'(bb);
    bus.start   = 1'b1;
    k = 0;
    forever begin
      @(negedge clk);
      k++;
      bus.start = 1'b0;
      if (abort_k != 0 && k == abort_k) begin
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_result", int'(bus.result), 0);
        exp_q.delete();
        addr_q.delete();
        sclr_q.delete();
        last_res = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        break;
      end
      if (!bus.busy) break;
      if (extra && (k == 2 || bus.done)) begin
        bus.vec_len = LEN_W'($urandom);
        bus.base_a  = ADDR_W'($urandom);
        bus.base_b  = ADDR_W'($urandom);
        bus.start   = 1'b1;
      end
      if (k > 600) begin
        chk("busy_timeout", 1, 0);
        break;
      end
    end
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    cyc = 0;
    last_res = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.vec_len = '0;
    bus.base_a = '0;
    bus.base_b = '0;
    for (int i = 0; i < 256; i++) begin
      ram_a[i] = 8'($urandom);
      ram_b[i] = 8'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      ram_a[i] = 8'(i + 1);
      ram_b[i] = 8'(i + 5);
    end
    for (int i = 100; i < 117; i++) begin
      ram_a[i] = 8'd255;
      ram_b[i] = 8'd255;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_result", int'(bus.result), 0);
    chk("rst_ovf", int'(bus.ovf), 0);
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_sclr", int'(bus.mac_sclr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run(4, 0, 0, 1'b0, 0, 1'b1, 70, 1'b0);
    run(0, 0, 0, 1'b0, 0, 1'b1, 0, 1'b0);
    run(17, 100, 100, 1'b0, 0, 1'b1, 56849, OVF_ON);
    run(16, 100, 100, 1'b0, 0, 1'b1, 1040400, 1'b0);
    run(4, 'hFE, 'h10, 1'b0, 0, 1'b0, 0, 1'b0);
    run(4, 0, 0, 1'b1, 0, 1'b1, 70, 1'b0);
    run(20, 'h30, 'h50, 1'b0, 6, 1'b0, 0, 1'b0);
    run(4, 0, 0, 1'b0, 0, 1'b1, 70, 1'b0);
    for (int t = 0; t < 14; t++)
      run(int'($urandom_range(0, 40)), int'($urandom_range(0, 255)),
          int'($urandom_range(0, 255)), 1'($urandom), 0, 1'b0, 0, 1'b0);
    run(255, 0, 0, 1'b0, 0, 1'b0, 0, 1'b0);

    repeat (4) @(negedge clk);
    chk("pending_done", exp_q.size(), 0);
    chk("pending_reads", addr_q.size(), 0);
    chk("pending_sclr", sclr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
